// File: rtl/conv_pkg.sv
// Shared types and constants for the 2x2 convolution window scheduler.
package conv_pkg;

  localparam int DATA_W_DFLT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_IMG = 3'd2,
    ISSUE    = 3'd3,
    FINISH   = 3'd4
  } state_e;

  // Number of 2x2 windows produced for an img_w x img_w feature map.
  function automatic int NUM_WIN(input int img_w);
    return (img_w - 1) * (img_w - 1);
  endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Beat inputs, datapath-facing outputs and status flags of the window scheduler.
interface conv_window_scheduler_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
);
  logic              kernel_valid;
  logic [DATA_W-1:0] In_Kernel;
  logic              pix_valid;
  logic [DATA_W-1:0] In_Pixel;
  logic              weight_valid;
  logic [DATA_W-1:0] Weight_1, Weight_2, Weight_3, Weight_4;
  logic              in_valid;
  logic [DATA_W-1:0] IFM_1, IFM_2, IFM_3, IFM_4;
  logic [3:0]        win_row, win_col;
  logic              busy, done, err;

  // Upstream source / controller side.
  modport master (
    output kernel_valid, In_Kernel, pix_valid, In_Pixel,
    input  weight_valid, Weight_1, Weight_2, Weight_3, Weight_4,
    input  in_valid, IFM_1, IFM_2, IFM_3, IFM_4, win_row, win_col,
    input  busy, done, err
  );

  // Scheduler side.
  modport slave (
    input  kernel_valid, In_Kernel, pix_valid, In_Pixel,
    output weight_valid, Weight_1, Weight_2, Weight_3, Weight_4,
    output in_valid, IFM_1, IFM_2, IFM_3, IFM_4, win_row, win_col,
    output busy, done, err
  );
endinterface

// File: rtl/conv_img_buf.sv
// Feature-map register file: one write port, four combinational reads
// returning the 2x2 window whose top-left corner is (row_i, col_i).
module conv_img_buf #(
  parameter int IMG_W  = 6,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(IMG_W * IMG_W)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [3:0]        row_i,
  input  logic [3:0]        col_i,
  output logic [DATA_W-1:0] px_o [4]
);

  logic [DATA_W-1:0] mem [IMG_W * IMG_W];

  function automatic logic [AW-1:0] addr(input logic [3:0] r, input logic [3:0] c);
    return AW'(int'(r) * IMG_W + int'(c));
  endfunction

  // Pixel write.
  // NOTE: the buffer has no reset; every entry is rewritten before ISSUE reads it.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Window read, ordered (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  always_comb begin
    px_o[0] = mem[addr(row_i,        col_i)];
    px_o[1] = mem[addr(row_i,        col_i + 4'd1)];
    px_o[2] = mem[addr(row_i + 4'd1, col_i)];
    px_o[3] = mem[addr(row_i + 4'd1, col_i + 4'd1)];
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Collects a 4-tap kernel and an IMG_W x IMG_W feature map, then streams
// every 2x2 window to the MAC datapath on consecutive cycles.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W  = 6,
  parameter int DATA_W = DATA_W_DFLT
) (
  input logic                    clk,
  input logic                    rst_n,
  conv_window_scheduler_if.slave bus
);

  localparam int         NPIX    = IMG_W * IMG_W;
  localparam int         PIX_W   = $clog2(NPIX);
  localparam logic [3:0] LAST_RC = 4'(IMG_W - 2);

  state_e            state_q;
  logic [1:0]        tap_q;
  logic [PIX_W-1:0]  pix_q;
  logic [DATA_W-1:0] w_q [4];
  logic [DATA_W-1:0] ifm_q [4];
  logic [3:0]        win_row_q, win_col_q;
  logic              weight_valid_q, in_valid_q, done_q, err_q;

  logic [3:0]        row_d, col_d, rd_row, rd_col;
  logic [DATA_W-1:0] rd_px [4];
  logic              last_win, buf_wr;

  // Next window coordinates and buffer read address.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    row_d = win_row_q;
    col_d = win_col_q + 4'd1;
    if (win_col_q == LAST_RC) begin
      row_d = win_row_q + 4'd1;
      col_d = '0;
    end
    rd_row = '0;
    rd_col = '0;
    if (state_q == ISSUE) begin
      rd_row = row_d;
      rd_col = col_d;
    end
  end

  assign last_win = (win_row_q == LAST_RC) && (win_col_q == LAST_RC);
  assign buf_wr   = (state_q == LOAD_IMG) && bus.pix_valid;

  conv_img_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W), .AW(PIX_W)) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr),
    .wr_addr_i (pix_q),
    .wr_data_i (bus.In_Pixel),
    .row_i     (rd_row),
    .col_i     (rd_col),
    .px_o      (rd_px)
  );

  // Frame sequencer: beat acceptance, window issue and status pulses.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tap_q          <= '0;
      pix_q          <= '0;
      w_q            <= '{default: '0};
      ifm_q          <= '{default: '0};
      win_row_q      <= '0;
      win_col_q      <= '0;
      weight_valid_q <= 1'b0;
      in_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      weight_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.kernel_valid) begin
            w_q[0]  <= bus.In_Kernel;
            tap_q   <= 2'd1;
            state_q <= LOAD_W;
          end
          err_q <= bus.pix_valid;
        end
        LOAD_W: begin
          if (bus.kernel_valid) begin
            w_q[tap_q] <= bus.In_Kernel;
            tap_q      <= tap_q + 2'd1;
            if (tap_q == 2'd3) begin
              weight_valid_q <= 1'b1;
              pix_q          <= '0;
              state_q        <= LOAD_IMG;
            end
          end
          err_q <= bus.pix_valid;
        end
        LOAD_IMG: begin
          if (bus.pix_valid) begin
            pix_q <= pix_q + 1'b1;
            if (pix_q == PIX_W'(NPIX - 1)) begin
              // Last pixel: present window (0,0) next cycle.
              state_q    <= ISSUE;
              in_valid_q <= 1'b1;
              ifm_q      <= rd_px;
              win_row_q  <= '0;
              win_col_q  <= '0;
            end
          end
          err_q <= bus.kernel_valid;
        end
        ISSUE: begin
          if (last_win) begin
            state_q    <= FINISH;
            in_valid_q <= 1'b0;
            ifm_q      <= '{default: '0};
            win_row_q  <= '0;
            win_col_q  <= '0;
            done_q     <= 1'b1;
          end else begin
            ifm_q     <= rd_px;
            win_row_q <= row_d;
            win_col_q <= col_d;
          end
          err_q <= bus.kernel_valid | bus.pix_valid;
        end
        FINISH: begin
          state_q <= IDLE;
          err_q   <= bus.kernel_valid | bus.pix_valid;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.weight_valid = weight_valid_q;
  assign bus.Weight_1     = w_q[0];
  assign bus.Weight_2     = w_q[1];
  assign bus.Weight_3     = w_q[2];
  assign bus.Weight_4     = w_q[3];
  assign bus.in_valid     = in_valid_q;
  assign bus.IFM_1        = ifm_q[0];
  assign bus.IFM_2        = ifm_q[1];
  assign bus.IFM_3        = ifm_q[2];
  assign bus.IFM_4        = ifm_q[3];
  assign bus.win_row      = win_row_q;
  assign bus.win_col      = win_col_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: a 6x6 build and a 3x3 build.
module tb_conv_window_scheduler;
  import conv_pkg::*;

  localparam int W6 = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] img6 [W6 * W6];

  always #5 clk = ~clk;

  conv_window_scheduler_if #(.DATA_W(8)) bus6 ();
  conv_window_scheduler_if #(.DATA_W(8)) bus3 ();

  conv_window_scheduler #(.IMG_W(6), .DATA_W(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  conv_window_scheduler #(.IMG_W(3), .DATA_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input logic [7:0] k0, k1, k2, k3);
    logic [7:0] k [4];
    k = '{k0, k1, k2, k3};
    for (int i = 0; i < 4; i++) begin
      bus6.kernel_valid = 1'b1;
      bus6.In_Kernel    = k[i];
      tick();
      if (i < 3) check("wv_early", bus6.weight_valid, 1'b0);
    end
    bus6.kernel_valid = 1'b0;
    check("wv_pulse", bus6.weight_valid, 1'b1);
    check("weight_1", bus6.Weight_1, k0);
    check("weight_2", bus6.Weight_2, k1);
    check("weight_3", bus6.Weight_3, k2);
    check("weight_4", bus6.Weight_4, k3);
    check("busy_load", bus6.busy, 1'b1);
    tick();
    check("wv_clear", bus6.weight_valid, 1'b0);
    check("weight_1_hold", bus6.Weight_1, k0);
  endtask

  task automatic load_pixels(input bit gaps);
    for (int k = 0; k < W6 * W6; k++) begin
      bus6.pix_valid = 1'b1;
      bus6.In_Pixel  = img6[k];
      tick();
      bus6.pix_valid = 1'b0;
      check("pix_err", bus6.err, 1'b0);
      if (k < W6 * W6 - 1) begin
        check("pix_inv", bus6.in_valid, 1'b0);
        if (gaps) tick();
      end
    end
  endtask

  task automatic check_window(input int w, input logic exp_err);
    int r, c, b;
    r = w / (W6 - 1);
    c = w % (W6 - 1);
    b = r * W6 + c;
    check($sformatf("w%0d_valid", w), bus6.in_valid, 1'b1);
    check($sformatf("w%0d_row", w),   bus6.win_row, r);
    check($sformatf("w%0d_col", w),   bus6.win_col, c);
    check($sformatf("w%0d_ifm1", w),  bus6.IFM_1, img6[b]);
    check($sformatf("w%0d_ifm2", w),  bus6.IFM_2, img6[b + 1]);
    check($sformatf("w%0d_ifm3", w),  bus6.IFM_3, img6[b + W6]);
    check($sformatf("w%0d_ifm4", w),  bus6.IFM_4, img6[b + W6 + 1]);
    check($sformatf("w%0d_err", w),   bus6.err, exp_err);
    check($sformatf("w%0d_done", w),  bus6.done, 1'b0);
  endtask

  // Walk all windows; optionally inject illegal beats or a reset at a window.
  task automatic run_windows(input int inject_at, input int reset_at);
    for (int w = 0; w < NUM_WIN(W6); w++) begin
      check_window(w, (w == inject_at + 1));
      if (w == reset_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_inv",  bus6.in_valid, 1'b0);
        check("rst_busy", bus6.busy, 1'b0);
        check("rst_done", bus6.done, 1'b0);
        check("rst_err",  bus6.err, 1'b0);
        check("rst_wv",   bus6.weight_valid, 1'b0);
        check("rst_w1",   bus6.Weight_1, 8'h00);
        check("rst_w4",   bus6.Weight_4, 8'h00);
        check("rst_ifm1", bus6.IFM_1, 8'h00);
        check("rst_ifm4", bus6.IFM_4, 8'h00);
        check("rst_row",  bus6.win_row, 4'd0);
        check("rst_col",  bus6.win_col, 4'd0);
        tick();
        check("rst_nodone", bus6.done, 1'b0);
        check("rst_idle",   bus6.busy, 1'b0);
        return;
      end
      if (w == inject_at) begin
        bus6.kernel_valid = 1'b1;
        bus6.In_Kernel    = 8'h55;
        bus6.pix_valid    = 1'b1;
        bus6.In_Pixel     = 8'h66;
      end
      tick();
      bus6.kernel_valid = 1'b0;
      bus6.pix_valid    = 1'b0;
    end
    check("fin_done",  bus6.done, 1'b1);
    check("fin_inv",   bus6.in_valid, 1'b0);
    check("fin_busy",  bus6.busy, 1'b1);
    check("fin_ifm1",  bus6.IFM_1, 8'h00);
    check("fin_row",   bus6.win_row, 4'd0);
    tick();
    check("idle_done", bus6.done, 1'b0);
    check("idle_busy", bus6.busy, 1'b0);
  endtask

  initial begin
    logic [7:0] exp3 [4][4];
    exp3 = '{'{8'd9, 8'd8, 8'd6, 8'd5}, '{8'd8, 8'd7, 8'd5, 8'd4},
             '{8'd6, 8'd5, 8'd3, 8'd2}, '{8'd5, 8'd4, 8'd2, 8'd1}};
    for (int k = 0; k < W6 * W6; k++) img6[k] = 8'(k);

    rst_n = 1'b0;
    bus6.kernel_valid = 1'b0; bus6.In_Kernel = '0; bus6.pix_valid = 1'b0; bus6.In_Pixel = '0;
    bus3.kernel_valid = 1'b0; bus3.In_Kernel = '0; bus3.pix_valid = 1'b0; bus3.In_Pixel = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state.
    check("reset_busy", bus6.busy, 1'b0);
    check("reset_inv",  bus6.in_valid, 1'b0);
    check("reset_wv",   bus6.weight_valid, 1'b0);
    check("reset_done", bus6.done, 1'b0);
    check("reset_err",  bus6.err, 1'b0);
    check("reset_w1",   bus6.Weight_1, 8'h00);
    check("reset_busy3", bus3.busy, 1'b0);

    // Pixel beat in IDLE: err pulse, stays IDLE.
    bus6.pix_valid = 1'b1;
    bus6.In_Pixel  = 8'hAA;
    tick();
    bus6.pix_valid = 1'b0;
    check("idle_pix_err",  bus6.err, 1'b1);
    check("idle_pix_busy", bus6.busy, 1'b0);
    tick();
    check("idle_pix_err_clr", bus6.err, 1'b0);
    check("idle_pix_busy2",   bus6.busy, 1'b0);

    // Frame A: contiguous pixels.
    load_kernel(8'd1, 8'd2, 8'd3, 8'd4);
    load_pixels(1'b0);
    run_windows(-10, -10);

    // Frame B: kernel accepted straight after done, pixels with gaps.
    load_kernel(8'd1, 8'd2, 8'd3, 8'd4);
    load_pixels(1'b1);
    run_windows(-10, -10);

    // Frame C: illegal beats during window 10.
    load_kernel(8'd1, 8'd2, 8'd3, 8'd4);
    load_pixels(1'b0);
    run_windows(10, -10);
    check("inject_w1_kept", bus6.Weight_1, 8'd1);

    // Frame D: reset at window 12, then Frame E with a new kernel.
    load_kernel(8'd1, 8'd2, 8'd3, 8'd4);
    load_pixels(1'b0);
    run_windows(-10, 12);
    load_kernel(8'd5, 8'd6, 8'd7, 8'd8);
    load_pixels(1'b0);
    run_windows(-10, -10);

    // 3x3 build: pixels 9..1.
    for (int i = 0; i < 4; i++) begin
      bus3.kernel_valid = 1'b1;
      bus3.In_Kernel    = 8'(i + 1);
      tick();
    end
    bus3.kernel_valid = 1'b0;
    check("w3_wv", bus3.weight_valid, 1'b1);
    check("w3_w4", bus3.Weight_4, 8'd4);
    for (int k = 0; k < 9; k++) begin
      bus3.pix_valid = 1'b1;
      bus3.In_Pixel  = 8'(9 - k);
      tick();
    end
    bus3.pix_valid = 1'b0;
    for (int w = 0; w < NUM_WIN(3); w++) begin
      check($sformatf("w3_%0d_valid", w), bus3.in_valid, 1'b1);
      check($sformatf("w3_%0d_row", w),   bus3.win_row, w / 2);
      check($sformatf("w3_%0d_col", w),   bus3.win_col, w % 2);
      check($sformatf("w3_%0d_ifm1", w),  bus3.IFM_1, exp3[w][0]);
      check($sformatf("w3_%0d_ifm2", w),  bus3.IFM_2, exp3[w][1]);
      check($sformatf("w3_%0d_ifm3", w),  bus3.IFM_3, exp3[w][2]);
      check($sformatf("w3_%0d_ifm4", w),  bus3.IFM_4, exp3[w][3]);
      tick();
    end
    check("w3_done", bus3.done, 1'b1);
    check("w3_inv",  bus3.in_valid, 1'b0);
    tick();
    check("w3_idle", bus3.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
